multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle RV32I main control FSM; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and a single memory port.
//  Adds a mem_ready handshake with timeout, I-type ALU and JAL classes, and sticky fault flags.
//  Drives the multi-cycle datapath. The datapath owns IR; opcode is IR[6:0].
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive mem_ready=0 cycles in a memory-wait state before fault (>=1)
//  SUPPORT_JAL  1   1: opcode 1101111 executes as JAL; 0: treated as illegal
//  ALUOP_W      2   ALUOp width; values 00 add, 01 sub/branch, 10 R-funct, 11 I-funct (>=2)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high reset
//  Opcode     in   7        IR[6:0]; sampled in DECODE only
//  mem_ready  in   1        memory completes the current read/write this cycle
//  PCWrite    out  1        unconditional PC load
//  PCSrc      out  1        0: PC <- ALU result; 1: PC <- ALUOut register
//  Branch     out  1        datapath loads PC if Branch & zero
//  IorD       out  1        memory address: 0 PC, 1 ALUOut
//  MemRead    out  1        memory read request
//  MemWrite   out  1        memory write request
//  IRWrite    out  1        load IR from memory data
//  MemtoReg   out  1        writeback source: 0 ALUOut, 1 MDR
//  RegWrite   out  1        register-file write enable
//  ALUSrcA    out  2        00 PC, 01 rs1, 10 oldPC
//  ALUSrcB    out  2        00 rs2, 01 const 4, 10 imm
//  ALUOp      out  ALUOP_W  ALU control class
//  illegal    out  1        sticky: unsupported opcode decoded
//  mem_fault  out  1        sticky: memory timeout
//  state      out  4        current state, for debug
// BEHAVIOUR
//  State register plus timeout counter (width $clog2(MEM_TIMEOUT+1)); outputs combinational from state and mem_ready.
//  Any output not listed for a state is 0.
//  Reset (async) -> state=FETCH, cnt=0, illegal=0, mem_fault=0; outputs = FETCH with mem_ready=0.
//  States and encodings:
//  FETCH(0): MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
//    If mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, next DECODE; else stay.
//  DECODE(1): ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch/JAL target -> ALUOut). Next state by Opcode:
//    0110011 EXEC_R; 0010011 EXEC_I; 0000011/0100011 MEMADR; 1100011 BRANCH;
//    1101111 JAL (if SUPPORT_JAL); other -> TRAP with illegal<=1.
//  MEMADR(2): ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next MEMRD if load, else MEMWR.
//    Opcode is held stable by IR.
//  MEMRD(3): MemRead=1, IorD=1. On mem_ready -> MEMWB.
//  MEMWB(4): RegWrite=1, MemtoReg=1 -> FETCH.
//  MEMWR(5): MemWrite=1, IorD=1. On mem_ready -> FETCH.
//  EXEC_R(6): ALUSrcA=01, ALUSrcB=00, ALUOp=10 -> ALUWB.
//  EXEC_I(8): ALUSrcA=01, ALUSrcB=10, ALUOp=11 -> ALUWB.
//  ALUWB(7): RegWrite=1, MemtoReg=0 -> FETCH.
//  BRANCH(9): Branch=1, PCSrc=1, ALUSrcA=01, ALUSrcB=00, ALUOp=01 -> FETCH.
//  JAL(10): PCWrite=1, PCSrc=1, ALUSrcA=10, ALUSrcB=01, ALUOp=00 (link=oldPC+4) -> ALUWB.
//  TRAP(11): all control outputs 0; stays until reset; only reset clears the sticky flags.
//  Timeout counter:
//    In FETCH/MEMRD/MEMWR, cnt increments each cycle with mem_ready=0.
//    cnt clears on leaving the state and on mem_ready=1.
//    When cnt==MEM_TIMEOUT-1 and mem_ready=0: next TRAP, mem_fault<=1, and no IRWrite/PCWrite that cycle.
//    mem_ready=1 in the same cycle as the timeout point wins: normal transition, no fault.
//  Unused encodings 12-15 -> TRAP next cycle, flags unchanged.
//  Reset mid-instruction aborts immediately; no partial RegWrite/MemWrite after the reset edge.
// TESTING
//  add (0110011), mem_ready=1 each fetch -> FETCH,DECODE,EXEC_R,ALUWB; RegWrite=1 only in cycle 4; 4 cycles.
//  lw (0000011), MEMRD mem_ready low 3 cycles -> 8 cycles total; MemtoReg=1, RegWrite=1 in MEMWB.
//  sw (0100011) -> MemWrite=1 in MEMWR only; RegWrite never 1; 4 cycles with ready=1.
//  beq (1100011) -> Branch=1, ALUOp=01 in cycle 3, then FETCH; JAL with SUPPORT_JAL=0 -> TRAP, illegal=1.
//  MEM_TIMEOUT=15, FETCH mem_ready=0 for 15 cycles -> TRAP, mem_fault=1; ready on 15th cycle -> DECODE.
//  Assert reset in MEMWR -> state=0, flags 0, MemWrite=0 within same cycle (async).

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Main control FSM for a multi-cycle RV32I datapath. It sequences fetch, decode,
// execute, memory and writeback, and raises sticky flags on illegal opcodes and on memory timeouts.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit SUPPORT_JAL = 1'b1,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               Branch,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               mem_fault,
  output logic [3:0]         state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_EXEC_I = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(3);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             mem_fault_q, mem_fault_d;
  logic             wait_state;
  logic             timeout;

  // Memory handshake: in FETCH/MEMRD/MEMWR the request is held every cycle until
  // memory answers with mem_ready=1, which completes the access in that same cycle.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout    = wait_state && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    mem_fault_d = mem_fault_q;
    if (wait_state && !mem_ready && !timeout) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (Opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL: begin
            if (SUPPORT_JAL) state_d = S_JAL;
            else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (timeout) mem_fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        // Branch/JAL target computed early into ALUOut.
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = ALU_R;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_I;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        Branch  = 1'b1;
        PCSrc   = 1'b1;
        ALUSrcA = 2'b01;
        ALUOp   = ALU_SUB;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link oldPC+4.
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign mem_fault = mem_fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instruction classes, the
// memory timeout boundary, illegal opcodes and asynchronous reset.
module tb_multicycle_control_unit;

  // {PCWrite,PCSrc,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [14:0] C_FETCH_NR = {9'b000010000, 6'b000100};
  localparam logic [14:0] C_FETCH_R  = {9'b100010100, 6'b000100};
  localparam logic [14:0] C_DECODE   = {9'b000000000, 6'b101000};
  localparam logic [14:0] C_MEMADR   = {9'b000000000, 6'b011000};
  localparam logic [14:0] C_MEMRD    = {9'b000110000, 6'b000000};
  localparam logic [14:0] C_MEMWB    = {9'b000000011, 6'b000000};
  localparam logic [14:0] C_MEMWR    = {9'b000101000, 6'b000000};
  localparam logic [14:0] C_EXEC_R   = {9'b000000000, 6'b010010};
  localparam logic [14:0] C_EXEC_I   = {9'b000000000, 6'b011011};
  localparam logic [14:0] C_ALUWB    = {9'b000000001, 6'b000000};
  localparam logic [14:0] C_BRANCH   = {9'b011000000, 6'b010001};
  localparam logic [14:0] C_JAL      = {9'b110000000, 6'b100100};
  localparam logic [14:0] C_TRAP     = 15'b0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;

  logic       PCWrite, PCSrc, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       illegal, mem_fault;
  logic [3:0] state;

  logic       n_PCWrite, n_PCSrc, n_Branch, n_IorD, n_MemRead, n_MemWrite, n_IRWrite;
  logic       n_MemtoReg, n_RegWrite, n_illegal, n_mem_fault;
  logic [1:0] n_ALUSrcA, n_ALUSrcB, n_ALUOp;
  logic [3:0] n_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(15), .SUPPORT_JAL(1'b1), .ALUOP_W(2)) u_dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal),
    .mem_fault(mem_fault), .state(state)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(15), .SUPPORT_JAL(1'b0), .ALUOP_W(2)) u_nojal (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(n_PCWrite), .PCSrc(n_PCSrc), .Branch(n_Branch), .IorD(n_IorD),
    .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
    .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA),
    .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .illegal(n_illegal),
    .mem_fault(n_mem_fault), .state(n_state)
  );

  function automatic logic [14:0] ctrl_now();
    return {PCWrite, PCSrc, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive inputs, check outputs, advance one cycle.
  task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                      input logic [3:0] exp_st, input logic [14:0] exp_ctrl);
    Opcode    = op;
    mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(state), 32'(exp_st));
    chk({tag, ".ctrl"}, 32'(ctrl_now()), 32'(exp_ctrl));
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag, input logic exp_ill, input logic exp_mf);
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    chk({tag, ".mem_fault"}, 32'(mem_fault), 32'(exp_mf));
  endtask

  initial begin
    reset     = 1'b1;
    Opcode    = OP_R;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.ctrl", 32'(ctrl_now()), 32'(C_FETCH_NR));
    chk_flags("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step("add.f", OP_R, 1'b1, 4'd0, C_FETCH_R);
    step("add.d", OP_R, 1'b0, 4'd1, C_DECODE);
    step("add.x", OP_R, 1'b0, 4'd6, C_EXEC_R);
    step("add.wb", OP_R, 1'b0, 4'd7, C_ALUWB);

    step("lw.f", OP_LW, 1'b1, 4'd0, C_FETCH_R);
    step("lw.d", OP_LW, 1'b0, 4'd1, C_DECODE);
    step("lw.adr", OP_LW, 1'b0, 4'd2, C_MEMADR);
    for (int i = 0; i < 3; i++) step("lw.rd_wait", OP_LW, 1'b0, 4'd3, C_MEMRD);
    step("lw.rd", OP_LW, 1'b1, 4'd3, C_MEMRD);
    step("lw.wb", OP_LW, 1'b0, 4'd4, C_MEMWB);

    step("sw.f", OP_SW, 1'b1, 4'd0, C_FETCH_R);
    step("sw.d", OP_SW, 1'b0, 4'd1, C_DECODE);
    step("sw.adr", OP_SW, 1'b0, 4'd2, C_MEMADR);
    step("sw.wr", OP_SW, 1'b1, 4'd5, C_MEMWR);

    step("addi.f", OP_I, 1'b1, 4'd0, C_FETCH_R);
    step("addi.d", OP_I, 1'b0, 4'd1, C_DECODE);
    step("addi.x", OP_I, 1'b0, 4'd8, C_EXEC_I);
    step("addi.wb", OP_I, 1'b0, 4'd7, C_ALUWB);

    step("beq.f", OP_BEQ, 1'b1, 4'd0, C_FETCH_R);
    step("beq.d", OP_BEQ, 1'b0, 4'd1, C_DECODE);
    step("beq.br", OP_BEQ, 1'b0, 4'd9, C_BRANCH);

    step("jal.f", OP_JAL, 1'b1, 4'd0, C_FETCH_R);
    step("jal.d", OP_JAL, 1'b0, 4'd1, C_DECODE);
    #1;
    chk("nojal.state", 32'(n_state), 32'd11);
    chk("nojal.illegal", 32'(n_illegal), 32'd1);
    chk("nojal.mem_fault", 32'(n_mem_fault), 32'd0);
    chk("nojal.RegWrite", 32'(n_RegWrite), 32'd0);
    chk_flags("jal", 1'b0, 1'b0);
    step("jal.j", OP_JAL, 1'b0, 4'd10, C_JAL);
    step("jal.wb", OP_JAL, 1'b0, 4'd7, C_ALUWB);

    // Ready arriving on the 15th waiting cycle must still complete the fetch.
    for (int i = 0; i < 14; i++) step("near.wait", OP_R, 1'b0, 4'd0, C_FETCH_NR);
    step("near.f15", OP_R, 1'b1, 4'd0, C_FETCH_R);
    step("near.d", OP_R, 1'b0, 4'd1, C_DECODE);
    chk_flags("near", 1'b0, 1'b0);
    step("near.x", OP_R, 1'b0, 4'd6, C_EXEC_R);
    step("near.wb", OP_R, 1'b0, 4'd7, C_ALUWB);

    for (int i = 0; i < 15; i++) step("to.wait", OP_R, 1'b0, 4'd0, C_FETCH_NR);
    step("to.trap", OP_R, 1'b1, 4'd11, C_TRAP);
    step("to.stay", OP_R, 1'b1, 4'd11, C_TRAP);
    #1;
    chk_flags("to", 1'b0, 1'b1);

    reset = 1'b1;
    #1;
    chk("rst_trap.state", 32'(state), 32'd0);
    chk_flags("rst_trap", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step("bad.f", OP_BAD, 1'b1, 4'd0, C_FETCH_R);
    step("bad.d", OP_BAD, 1'b0, 4'd1, C_DECODE);
    step("bad.trap", OP_BAD, 1'b1, 4'd11, C_TRAP);
    #1;
    chk_flags("bad", 1'b1, 1'b0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("arst.f", OP_SW, 1'b1, 4'd0, C_FETCH_R);
    step("arst.d", OP_SW, 1'b0, 4'd1, C_DECODE);
    step("arst.adr", OP_SW, 1'b0, 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    #1;
    chk("arst.pre_state", 32'(state), 32'd5);
    chk("arst.pre_MemWrite", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst.state", 32'(state), 32'd0);
    chk("arst.MemWrite", 32'(MemWrite), 32'd0);
    chk("arst.RegWrite", 32'(RegWrite), 32'd0);
    chk_flags("arst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("post.f", OP_R, 1'b1, 4'd0, C_FETCH_R);
    step("post.d", OP_R, 1'b0, 4'd1, C_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
